// File: rtl/regfile_pkg.sv
// regfile_pkg: shared helpers for the multi-port register file (REGFILE_BYPASS_EN enables same-cycle write bypass in reg_file_mp)
`ifndef REGFILE_PKG_MACROS
`define REGFILE_PKG_MACROS
`define RF_SLICE(v, i, w) v[(i)*(w) +: (w)]
`endif
package regfile_pkg;
  localparam int V0_DEF = 2;
  localparam int A0_DEF = 4;
  function automatic int addr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits, set at issue and cleared at writeback
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int NUM_WR   = 2,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_id,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_id,
  output logic [NUM_REGS-1:0]      busy
);
  localparam bit ZR = ZERO_REG != 0;
  logic [NUM_REGS-1:0] set, clr;
  // issue marks the destination busy; any write to a register clears it
  always_comb begin
    set = '0;
    clr = '0;
    for (int r = 0; r < NUM_REGS; r++)
      set[r] = issue_en && issue_id == ADDR_W'(r) && !(ZR && r == 0);
    for (int k = 0; k < NUM_WR; k++)
      if (wr_en[k]) clr[`RF_SLICE(wr_id, k, ADDR_W)] = 1'b1;
  end
  // issue wins over a same-cycle clear
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) busy <= '0;
    else busy <= (busy & ~clr) | set;
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: NUM_RD x NUM_WR register file with busy scoreboard and syscall taps; REGFILE_BYPASS_EN adds write-to-read bypass
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  parameter int V0_IDX   = V0_DEF,
  parameter int A0_IDX   = A0_DEF,
  localparam int ADDR_W  = addr_w(NUM_REGS)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_id,
  output logic [NUM_RD*DATA_W-1:0] rd_value,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_id,
  input  logic [NUM_WR*DATA_W-1:0] wr_value,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_id,
  output logic                     wr_conflict,
  output logic [DATA_W-1:0]        syscall_funct,
  output logic [DATA_W-1:0]        syscall_param1
);
  localparam bit ZR = ZERO_REG != 0;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0]             busy;
  logic                            conf;

  regfile_scoreboard #(
    .NUM_REGS(NUM_REGS), .NUM_WR(NUM_WR), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clock(clock), .reset_n(reset_n), .issue_en(issue_en), .issue_id(issue_id),
    .wr_en(wr_en), .wr_id(wr_id), .busy(busy)
  );

  // commit writes in ascending port order so the highest enabled port wins
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) regs <= '0;
    else
      for (int k = 0; k < NUM_WR; k++)
        if (wr_en[k] && !(ZR && `RF_SLICE(wr_id, k, ADDR_W) == '0))
          regs[`RF_SLICE(wr_id, k, ADDR_W)] <= `RF_SLICE(wr_value, k, DATA_W);

  // flag two or more enabled writes hitting the same writable register
  always_comb begin
    conf = 1'b0;
    for (int i = 0; i < NUM_WR; i++)
      for (int j = i + 1; j < NUM_WR; j++)
        if (wr_en[i] && wr_en[j] && `RF_SLICE(wr_id, i, ADDR_W) == `RF_SLICE(wr_id, j, ADDR_W) &&
            !(ZR && `RF_SLICE(wr_id, i, ADDR_W) == '0))
          conf = 1'b1;
  end

  // conflict is reported in the cycle after it happens
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) wr_conflict <= 1'b0;
    else wr_conflict <= conf;

  // combinational read muxes, optionally overridden by same-cycle writes
  always_comb begin
    rd_value = '0;
    rd_busy  = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      `RF_SLICE(rd_value, p, DATA_W) = regs[`RF_SLICE(rd_id, p, ADDR_W)];
      rd_busy[p] = busy[`RF_SLICE(rd_id, p, ADDR_W)];
`ifdef REGFILE_BYPASS_EN
      for (int k = 0; k < NUM_WR; k++)
        if (wr_en[k] && `RF_SLICE(wr_id, k, ADDR_W) == `RF_SLICE(rd_id, p, ADDR_W) &&
            !(ZR && `RF_SLICE(rd_id, p, ADDR_W) == '0)) begin
          `RF_SLICE(rd_value, p, DATA_W) = `RF_SLICE(wr_value, k, DATA_W);
          rd_busy[p] = issue_en && issue_id == `RF_SLICE(rd_id, p, ADDR_W);
        end
`endif
    end
  end

  assign syscall_funct  = regs[V0_IDX];
  assign syscall_param1 = regs[A0_IDX];
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed self-checking bench for reg_file_mp
module tb_reg_file_mp;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  rd_id = '0;
  logic [63:0] rd_value;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en = '0;
  logic [9:0]  wr_id = '0;
  logic [63:0] wr_value = '0;
  logic        issue_en = 1'b0;
  logic [4:0]  issue_id = '0;
  logic        wr_conflict;
  logic [31:0] syscall_funct, syscall_param1;
  int total = 0;
  int bad = 0;
  reg_file_mp dut (
    .clock(clock), .reset_n(reset_n), .rd_id(rd_id), .rd_value(rd_value), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_id(wr_id), .wr_value(wr_value), .issue_en(issue_en), .issue_id(issue_id),
    .wr_conflict(wr_conflict), .syscall_funct(syscall_funct), .syscall_param1(syscall_param1)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic idle();
    wr_en = '0;
    issue_en = 1'b0;
  endtask
  initial begin
    #1;
    check("rst_val", rd_value, 64'h0);
    check("rst_busy", {62'h0, rd_busy}, 64'h0);
    check("rst_conf", {63'h0, wr_conflict}, 64'h0);
    tick();
    reset_n = 1'b1;
    // test 1: write r5, issue r5, then reset mid-run
    wr_en = 2'b01; wr_id = {5'd0, 5'd5}; wr_value = {32'h0, 32'hDEADBEEF};
    rd_id = {5'd0, 5'd5};
    tick();
    idle();
    check("t1_wr", {32'h0, rd_value[31:0]}, 64'hDEADBEEF);
    issue_en = 1'b1; issue_id = 5'd5;
    tick();
    idle();
    check("t1_busy", {62'h0, rd_busy}, 64'h1);
    reset_n = 1'b0;
    #1;
    check("t1_rst_val", {32'h0, rd_value[31:0]}, 64'h0);
    check("t1_rst_busy", {62'h0, rd_busy}, 64'h0);
    issue_en = 1'b1; issue_id = 5'd5;
    wr_en = 2'b01; wr_value = {32'h0, 32'h1234};
    tick();
    idle();
    reset_n = 1'b1;
    tick();
    check("t1_post_busy", {62'h0, rd_busy}, 64'h0);
    check("t1_post_val", {32'h0, rd_value[31:0]}, 64'h0);
    // test 2: both ports write r3, port1 wins and conflict pulses once
    wr_en = 2'b11; wr_id = {5'd3, 5'd3}; wr_value = {32'h22, 32'h11};
    rd_id = {5'd0, 5'd3};
    #1;
    check("t2_pre_conf", {63'h0, wr_conflict}, 64'h0);
    tick();
    idle();
    check("t2_val", {32'h0, rd_value[31:0]}, 64'h22);
    check("t2_conf", {63'h0, wr_conflict}, 64'h1);
    tick();
    check("t2_conf_clr", {63'h0, wr_conflict}, 64'h0);
    // test 3: issue r7, write r7 two cycles later
    rd_id = {5'd0, 5'd7};
    issue_en = 1'b1; issue_id = 5'd7;
    tick();
    idle();
    check("t3_busy_c1", {62'h0, rd_busy}, 64'h1);
    tick();
    check("t3_busy_c2", {62'h0, rd_busy}, 64'h1);
    wr_en = 2'b10; wr_id = {5'd7, 5'd0}; wr_value = {32'h70, 32'h0};
    tick();
    idle();
    check("t3_busy_clr", {62'h0, rd_busy}, 64'h0);
    check("t3_val", {32'h0, rd_value[31:0]}, 64'h70);
    // test 4: issue and write r7 in the same cycle
    issue_en = 1'b1; issue_id = 5'd7;
    wr_en = 2'b01; wr_id = {5'd0, 5'd7}; wr_value = {32'h0, 32'h77};
    tick();
    idle();
    check("t4_busy", {62'h0, rd_busy}, 64'h1);
    check("t4_val", {32'h0, rd_value[31:0]}, 64'h77);
    // test 5: writes and issue to r0 are dropped
    rd_id = {5'd7, 5'd0};
    wr_en = 2'b11; wr_id = {5'd0, 5'd0}; wr_value = {32'h9, 32'h5};
    issue_en = 1'b1; issue_id = 5'd0;
    tick();
    idle();
    check("t5_val", {32'h0, rd_value[31:0]}, 64'h0);
    check("t5_busy", {63'h0, rd_busy[0]}, 64'h0);
    check("t5_conf", {63'h0, wr_conflict}, 64'h0);
    check("t5_r7_keep", {32'h0, rd_value[63:32]}, 64'h77);
    // test 6: distinct writes r2/r4 while reading them
    rd_id = {5'd4, 5'd2};
    wr_en = 2'b11; wr_id = {5'd4, 5'd2}; wr_value = {32'hB, 32'hA};
    #1;
`ifdef REGFILE_BYPASS_EN
    check("t6_same_cyc", rd_value, {32'hB, 32'hA});
`else
    check("t6_same_cyc", rd_value, 64'h0);
`endif
    check("t6_tap_old", {syscall_param1, syscall_funct}, 64'h0);
    tick();
    idle();
    check("t6_next", rd_value, {32'hB, 32'hA});
    check("t6_funct", {32'h0, syscall_funct}, 64'hA);
    check("t6_param1", {32'h0, syscall_param1}, 64'hB);
    check("t6_conf", {63'h0, wr_conflict}, 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
